// File: rtl/packConv.sv
// Shared element width and frame types for the convolution datapath.
// A frame is nine signed words, element k = row*3 + col.
package packConv;

    localparam int W = 16;

    typedef logic signed [W-1:0] word_t;
    typedef word_t param9 [9];

endpackage

// File: rtl/conv_result_streamer_if.sv
// Output beat stream of conv_result_streamer.
// master drives the beats, slave returns m_ready.
interface conv_result_streamer_if;
    import packConv::*;

    logic        m_valid;
    logic        m_ready;
    word_t       m_data;
    logic [3:0]  m_index;
    logic [1:0]  m_row;
    logic [1:0]  m_col;
    logic        m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_row,
        output m_col,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_row,
        input  m_col,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/conv_result_streamer.sv
// Buffers 3x3 convolution frames in a ping-pong pair and
// streams them out one word per beat with valid/ready.
module conv_result_streamer
    import packConv::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  param9                         in_map,
    input  logic                          clear,
    conv_result_streamer_if.master        st,
    output logic                          busy,
    output logic                          overflow
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state;
    logic       wr;
    logic       rd;
    logic [1:0] count;
    logic [3:0] idx;
    logic [1:0] row;
    logic [1:0] col;

    word_t      buffer [2][9];

    logic       xfer;
    logic       last_xfer;
    logic       accept;
    logic       drop;
    logic [1:0] count_nx;

    always_comb begin
        xfer      = (state == SEND) && st.m_ready;
        last_xfer = xfer && (idx == 4'd8);
        // a full pair still takes a frame when its oldest one leaves now
        accept    = in_valid && ((count != 2'd2) || last_xfer);
        drop      = in_valid && (count == 2'd2) && !last_xfer;
        count_nx  = count + {1'b0, accept} - {1'b0, last_xfer};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 9; k++) begin
                buffer[wr][k] <= in_map[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr       <= 1'b0;
            rd       <= 1'b0;
            count    <= 2'd0;
            idx      <= 4'd0;
            row      <= 2'd0;
            col      <= 2'd0;
            overflow <= 1'b0;
        end else begin
            count <= count_nx;
            if (accept) begin
                wr <= ~wr;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear) begin
                overflow <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (count != 2'd0) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        idx <= 4'd0;
                        row <= 2'd0;
                        col <= 2'd0;
                        rd  <= ~rd;
                        if (count_nx == 2'd0) begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        idx <= idx + 4'd1;
                        if (col == 2'd2) begin
                            col <= 2'd0;
                            row <= row + 2'd1;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign st.m_valid = (state == SEND);
    assign st.m_data  = buffer[rd][idx];
    assign st.m_index = idx;
    assign st.m_row   = row;
    assign st.m_col   = col;
    assign st.m_last  = (state == SEND) && (idx == 4'd8);
    assign busy       = (count != 2'd0) || (state == SEND);

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: single frame, backpressure,
// back-to-back, overflow, full-pair handover and mid-frame reset.
module tb_conv_result_streamer;
    import packConv::*;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  in_valid = 1'b0;
    logic  clear = 1'b0;
    logic  busy;
    logic  overflow;
    param9 in_map;

    int checks = 0;
    int errors = 0;
    int span;

    conv_result_streamer_if st ();

    conv_result_streamer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_map   (in_map),
        .clear    (clear),
        .st       (st.master),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int base);
        in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_map[k] = word_t'(base + k);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Consume n beats; frame f of the sequence holds base_f + k.
    task automatic stream(input int b0, input int b1, input int b2,
                          input int n, input bit bp,
                          output int sp);
        int    got;
        int    first;
        int    lastc;
        word_t pd;
        logic [3:0] pi;
        bit    pv;
        bit    pr;
        got   = 0;
        first = -1;
        lastc = 0;
        pd    = '0;
        pi    = '0;
        pv    = 1'b0;
        pr    = 1'b1;
        for (int c = 0; c < 400 && got < n; c++) begin
            st.m_ready = bp ? (c % 3 == 0) : 1'b1;
            if (pv && !pr) begin
                check("hold_data", st.m_data, pd);
                check("hold_idx", st.m_index, pi);
            end
            if (st.m_valid && st.m_ready) begin
                int k;
                int b;
                k = got % 9;
                b = (got < 9) ? b0 : ((got < 18) ? b1 : b2);
                check("data", st.m_data, b + k);
                check("index", st.m_index, k);
                check("row", st.m_row, k / 3);
                check("col", st.m_col, k % 3);
                check("last", st.m_last, (k == 8));
                if (first < 0) first = c;
                lastc = c;
                got++;
            end
            pv = st.m_valid;
            pr = st.m_ready;
            pd = st.m_data;
            pi = st.m_index;
            tick();
        end
        check("beats", got, n);
        sp = lastc - first;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st.m_ready = 1'b0;
        for (int k = 0; k < 9; k++) in_map[k] = '0;

        #1 reset = 1'b1;
        #3;
        check("rst_valid", st.m_valid, 0);
        check("rst_last", st.m_last, 0);
        check("rst_index", st.m_index, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // single frame and latency
        st.m_ready = 1'b1;
        send(1);
        check("lat_n", st.m_valid, 0);
        check("busy_buf", busy, 1);
        tick();
        check("lat_n1", st.m_valid, 1);
        stream(1, 0, 0, 9, 1'b0, span);
        check("busy_end", busy, 0);

        // backpressure
        send(1);
        stream(1, 0, 0, 9, 1'b1, span);
        check("bp_busy", busy, 0);

        // two frames, no bubble
        fork
            begin
                send(1);
                tick();
                send(11);
            end
            stream(1, 11, 0, 18, 1'b0, span);
        join
        check("b2b_span", span, 17);

        // overflow; clear coincident with the drop keeps it set
        st.m_ready = 1'b0;
        send(1);
        send(11);
        clear = 1'b1;
        send(31);
        clear = 1'b0;
        check("ovf_set", overflow, 1);
        tick();
        check("ovf_hold", st.m_valid, 1);
        stream(1, 11, 0, 18, 1'b0, span);
        for (int i = 0; i < 3; i++) begin
            check("no_c", st.m_valid, 0);
            tick();
        end
        check("ovf_sticky", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovf_clr", overflow, 0);

        // third frame lands on the last beat of the first
        st.m_ready = 1'b0;
        send(1);
        send(11);
        fork
            stream(1, 11, 41, 27, 1'b0, span);
            begin
                int w;
                w = 0;
                while (!(st.m_valid && st.m_index == 4'd8) && w < 100) begin
                    tick();
                    w++;
                end
                check("sync_wait", (w < 100), 1);
                check("sync_cnt2", busy, 1);
                send(41);
            end
        join
        check("sync_ovf", overflow, 0);
        check("sync_span", span, 26);
        check("sync_busy", busy, 0);

        // reset in the middle of a frame
        st.m_ready = 1'b1;
        send(1);
        begin
            int w;
            w = 0;
            while (!(st.m_valid && st.m_index == 4'd4) && w < 50) begin
                tick();
                w++;
            end
            check("mid_wait", (w < 50), 1);
        end
        reset = 1'b1;
        #1;
        check("mid_valid", st.m_valid, 0);
        check("mid_index", st.m_index, 0);
        check("mid_last", st.m_last, 0);
        check("mid_busy", busy, 0);
        check("mid_ovf", overflow, 0);
        tick();
        reset = 1'b0;
        tick();
        send(21);
        stream(21, 0, 0, 9, 1'b0, span);
        check("post_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
